// File: rtl/inv_sub_bytes_engine.sv
// Iterative AES inverse SubBytes: LANES inverse S-boxes reused over 16/LANES beats.
// Optional build macro INV_SUB_BYTES_SELFCHECK_EN adds forward S-box re-encryption checking on chk_err.
module inv_sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         chk_err
);
  localparam int N  = 16 / LANES;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  // state | meaning: IDLE | wait for block; SUB | substitute one beat per cycle; DONE | hold result until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  logic [1:0]         state;
  logic [BW-1:0]      beat;
  logic [127:0]       st;
  logic [LANES*8-1:0] sub_in;
  logic [LANES*8-1:0] inv_out;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_state = st;

  always_comb begin
    sub_in = '0;
    for (int l = 0; l < LANES; l++)
      sub_in[8*l +: 8] = st[8*(int'(beat)*LANES + l) +: 8];
  end

  always_comb begin
    inv_out = '0;
    for (int l = 0; l < LANES; l++)
      inv_out[8*l +: 8] = inv_sbox(sub_in[8*l +: 8]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      beat  <= '0;
      st    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            st    <= in_state;
            beat  <= '0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          for (int l = 0; l < LANES; l++)
            st[8*(int'(beat)*LANES + l) +: 8] <= inv_out[8*l +: 8];
          if (beat == LAST) begin
            beat  <= '0;
            state <= S_DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INV_SUB_BYTES_SELFCHECK_EN
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  logic lane_err;
  logic chk_err_q;

  // Re-encrypting each substituted byte must reproduce the byte that went in.
  always_comb begin
    lane_err = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (fwd_sbox(inv_out[8*l +: 8]) != sub_in[8*l +: 8]) lane_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                chk_err_q <= 1'b0;
    else if (state == S_IDLE && in_valid)   chk_err_q <= 1'b0;
    else if (state == S_SUB && lane_err)    chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed bench for inv_sub_bytes_engine: LANES=4 main instance plus LANES 1/2/16 sweep instances.
// Expected chk_err under forced S-box fault depends on INV_SUB_BYTES_SELFCHECK_EN.
module tb_inv_sub_bytes_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         chk_err;

  inv_sub_bytes_engine #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .chk_err(chk_err)
  );

  logic         sw_valid = 1'b0;
  logic [127:0] sw_state = '0;
  logic         sw_ready = 1'b1;
  logic         rdy1, rdy2, rdy16, ov1, ov2, ov16, ce1, ce2, ce16;
  logic [127:0] os1, os2, os16;

  inv_sub_bytes_engine #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy1), .in_state(sw_state),
    .out_valid(ov1), .out_ready(sw_ready), .out_state(os1), .chk_err(ce1)
  );
  inv_sub_bytes_engine #(.LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy2), .in_state(sw_state),
    .out_valid(ov2), .out_ready(sw_ready), .out_state(os2), .chk_err(ce2)
  );
  inv_sub_bytes_engine #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16), .in_state(sw_state),
    .out_valid(ov16), .out_ready(sw_ready), .out_state(os16), .chk_err(ce16)
  );

`ifdef INV_SUB_BYTES_SELFCHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [127:0] VEC_IN  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] VEC_OUT = 128'h00112233445566778899aabbccddeeff;

  // Forward S-box; the reference inverse is found by searching it.
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  int checks   = 0;
  int failures = 0;
  int lat;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      for (int x = 0; x < 256; x++)
        if (FWD[2047 - 8*x -: 8] == d[8*k +: 8]) r[8*k +: 8] = 8'(x);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    if (!in_ready) chk("send_ready_timeout", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_state = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    int c;
    l = -1;
    c = 0;
    while (l < 0 && c < 40) begin
      tick();
      c++;
      if (out_valid) l = c;
    end
  endtask

  task automatic run_sweep(input logic [127:0] d);
    int l1, l2, l16;
    logic [127:0] o1, o2, o16, exp;
    l1 = -1; l2 = -1; l16 = -1;
    o1 = '0; o2 = '0; o16 = '0;
    exp = ref_inv(d);
    sw_state = d;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (ov1  && l1  < 0) begin l1  = c; o1  = os1;  end
      if (ov2  && l2  < 0) begin l2  = c; o2  = os2;  end
      if (ov16 && l16 < 0) begin l16 = c; o16 = os16; end
    end
    chk("sweep_l1_lat",   128'(l1),  128'd16);
    chk("sweep_l1_data",  o1,  exp);
    chk("sweep_l2_lat",   128'(l2),  128'd8);
    chk("sweep_l2_data",  o2,  exp);
    chk("sweep_l16_lat",  128'(l16), 128'd1);
    chk("sweep_l16_data", o16, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_chk_err",   128'(chk_err),   128'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // FIPS-197 vector
    send(VEC_IN);
    wait_out(lat);
    chk("vec_latency", 128'(lat), 128'd4);
    chk("vec_data",    out_state, VEC_OUT);
    chk("vec_chk_err", 128'(chk_err), 128'd0);
    out_ready = 1'b1;
    tick();
    chk("vec_release_valid", 128'(out_valid), 128'd0);
    chk("vec_release_ready", 128'(in_ready),  128'd1);
    out_ready = 1'b0;

    // back-to-back with out_ready high
    out_ready = 1'b1;
    in_state  = {16{8'h63}};
    in_valid  = 1'b1;
    tick();
    in_state = {16{8'h00}};
    repeat (3) tick();
    chk("b2b_busy_c3", 128'(in_ready), 128'd0);
    tick();
    chk("b2b_valid_c4", 128'(out_valid), 128'd1);
    chk("b2b_data0",    out_state, {16{8'h00}});
    chk("b2b_busy_c4",  128'(in_ready), 128'd0);
    tick();
    chk("b2b_valid_c5", 128'(out_valid), 128'd0);
    chk("b2b_idle_c5",  128'(in_ready),  128'd1);
    tick();
    chk("b2b_accept_c6", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_latency2", 128'(lat), 128'd4);
    chk("b2b_data1",    out_state, {16{8'h52}});
    tick();
    chk("b2b_final_idle", 128'(in_ready), 128'd1);
    out_ready = 1'b0;

    // stall in DONE with in_valid pulses
    send({16{8'h16}});
    wait_out(lat);
    chk("stall_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_state = {16{8'h5a}};
      tick();
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_data",  out_state, {16{8'hff}});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", 128'(out_valid), 128'd0);
    chk("stall_release_ready", 128'(in_ready),  128'd1);
    out_ready = 1'b0;
    tick();
    chk("stall_no_phantom", 128'(in_ready), 128'd1);

    // reset during the second SUB beat
    in_state = {16{8'hed}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_in_ready",  128'(in_ready),  128'd1);
    chk("abort_out_state", out_state, 128'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    send({16{8'hed}});
    wait_out(lat);
    chk("after_abort_latency", 128'(lat), 128'd4);
    chk("after_abort_data",    out_state, {16{8'h53}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // LANES sweep
    run_sweep(VEC_IN);
    run_sweep({$urandom, $urandom, $urandom, $urandom});

    // forced single-bit fault on lane 0 of the inverse S-box bank
    force dut.inv_out = 32'h0000_0001;
    send({16{8'h63}});
    wait_out(lat);
    chk("fault_latency", 128'(lat), 128'd4);
    chk("fault_data",    out_state, 128'h00000001000000010000000100000001);
    chk("fault_chk_err", 128'(chk_err), 128'(EXP_ERR));
    release dut.inv_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send({16{8'h63}});
    chk("fault_clear_on_accept", 128'(chk_err), 128'd0);
    wait_out(lat);
    chk("clean_chk_err", 128'(chk_err), 128'd0);
    chk("clean_data",    out_state, {16{8'h00}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
